// File: rtl/ifu_fetch_if.sv
// Fetch-stage handshake bundle: imem request/response, decode handoff, next-PC input, fault status.
interface ifu_fetch_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        pc_next_valid;
  logic [31:0] pc_next;
  logic        fetch_fault;
  logic [1:0]  fault_cause;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_fault, fault_cause,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err, inst_ready,
           pc_next_valid, pc_next
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_fault, fault_cause,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err, inst_ready,
           pc_next_valid, pc_next
  );
endinterface

// File: rtl/ifu_fetch.sv
// Multi-cycle fetch: >=2 cycles req->inst, holds request/inst stable under backpressure, sticky faults.
// Optional IFU_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  ifu_fetch_if.master bus
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam logic [2:0] S_REQ   = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd2;
  localparam logic [2:0] S_NEXT  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  logic [2:0]  state, state_nxt;
  logic [31:0] pc, inst_q, inst_pc_q;
  logic        req_valid_q, inst_valid_q, fault_q;
  logic [1:0]  cause_q, cause_nxt;
  logic [7:0]  cnt, cnt_inc;
  logic        req_fire, dec_fire, in_fetch, to_hit;
  logic        rsp_ok, rsp_bad, pc_take, pc_bad;

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = pc;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;
  assign bus.fetch_fault    = fault_q;
  assign bus.fault_cause    = cause_q;

  assign req_fire = req_valid_q & bus.imem_req_ready;
  assign dec_fire = inst_valid_q & bus.inst_ready;
  assign in_fetch = (state == S_REQ) || (state == S_WAIT);
  assign cnt_inc  = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  assign to_hit   = in_fetch && (cnt_inc >= TIMEOUT);
  assign rsp_ok   = (state == S_WAIT) && bus.imem_rsp_valid && !bus.imem_rsp_err;
  assign rsp_bad  = (state == S_WAIT) && bus.imem_rsp_valid && bus.imem_rsp_err;
  assign pc_take  = bus.pc_next_valid && (((state == S_HOLD) && dec_fire) || (state == S_NEXT));
  assign pc_bad   = pc_take && (bus.pc_next[1:0] != 2'b00);

  always_comb begin
    state_nxt = state;
    cause_nxt = 2'b00;
    case (state)
      S_REQ:   if (req_fire) state_nxt = S_WAIT;
      S_WAIT:  if (rsp_ok) state_nxt = S_HOLD;
      S_HOLD:  if (dec_fire) state_nxt = pc_take ? S_REQ : S_NEXT;
      S_NEXT:  if (pc_take) state_nxt = S_REQ;
      default: state_nxt = S_FAULT;
    endcase
    // Fault overrides; bus error outranks a timeout landing in the same cycle.
    if (rsp_bad) begin
      state_nxt = S_FAULT;
      cause_nxt = 2'b01;
    end else if (to_hit) begin
      state_nxt = S_FAULT;
      cause_nxt = 2'b11;
    end else if (pc_bad) begin
      state_nxt = S_FAULT;
      cause_nxt = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_REQ;
      pc           <= RESET_PC;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'd0;
      inst_pc_q    <= 32'd0;
      fault_q      <= 1'b0;
      cause_q      <= 2'b00;
      cnt          <= 8'd0;
    end else begin
      state        <= state_nxt;
      req_valid_q  <= (state_nxt == S_REQ);
      inst_valid_q <= (state_nxt == S_HOLD);
      if ((state != S_FAULT) && (state_nxt == S_FAULT)) begin
        fault_q <= 1'b1;
        cause_q <= cause_nxt;
      end
      if ((state == S_WAIT) && (state_nxt == S_HOLD)) begin
        inst_q    <= bus.imem_rsp_data;
        inst_pc_q <= pc;
      end
      if ((state_nxt == S_REQ) && ((state == S_HOLD) || (state == S_NEXT))) begin
        pc <= bus.pc_next;
      end
      if (state_nxt == S_HOLD) begin
        cnt <= 8'd0;
      end else if (in_fetch) begin
        cnt <= cnt_inc;
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt <= 32'd0;
      perf_stall_cnt <= 32'd0;
    end else if (state != S_FAULT) begin
      if (dec_fire) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (in_fetch) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios plus randomized handshakes against a transaction-level model.
module tb_ifu_fetch;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int TO_MAIN = 255;
  localparam int P_REQ = 0, P_WAIT = 1, P_HOLD = 2, P_NEXT = 3, P_FAULT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ifu_fetch_if bus();
  ifu_fetch_if tbus();

`ifdef IFU_PERF_CNT_EN
  logic [31:0] pf, ps, tpf, tps;
  ifu_fetch dut (.clk(clk), .rst(rst), .bus(bus), .perf_fetch_cnt(pf), .perf_stall_cnt(ps));
  ifu_fetch #(.TIMEOUT(8'd8)) dut_to (.clk(clk), .rst(rst), .bus(tbus),
                                      .perf_fetch_cnt(tpf), .perf_stall_cnt(tps));
`else
  ifu_fetch dut (.clk(clk), .rst(rst), .bus(bus));
  ifu_fetch #(.TIMEOUT(8'd8)) dut_to (.clk(clk), .rst(rst), .bus(tbus));
`endif

  int total = 0;
  int bad = 0;
  int phase;
  bit fresh;
  int m_cnt;
  int since;
  logic [31:0] m_pc, m_inst, n_fire, n_stall;
  logic [1:0]  m_cause;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic void go_fault(input logic [1:0] c);
    phase   = P_FAULT;
    m_cause = c;
  endfunction

  function automatic void take_pc(input logic [31:0] pn);
    if (pn[1:0] != 2'b00) go_fault(2'b10);
    else begin
      m_pc  = pn;
      phase = P_REQ;
    end
  endfunction

  // One clock: check outputs seen now, drive inputs for the coming edge, advance the model.
  task automatic cyc(input bit rdy, input bit rv, input bit re, input logic [31:0] rd,
                     input bit ir, input bit pv, input logic [31:0] pn);
    chk1("req_valid", bus.imem_req_valid, (phase == P_REQ) && !fresh);
    if (phase == P_REQ && !fresh) chk32("req_addr", bus.imem_req_addr, m_pc);
    chk1("inst_valid", bus.inst_valid, phase == P_HOLD);
    if (phase == P_HOLD) begin
      chk32("inst", bus.inst, m_inst);
      chk32("inst_pc", bus.inst_pc, m_pc);
    end
    chk1("fetch_fault", bus.fetch_fault, phase == P_FAULT);
    chk2("fault_cause", bus.fault_cause, m_cause);
`ifdef IFU_PERF_CNT_EN
    chk32("perf_fetch", pf, n_fire);
    chk32("perf_stall", ps, n_stall);
`endif
    if (since <= 10) begin
      chk1("to_fault", tbus.fetch_fault, since >= 8);
      if (since >= 8) begin
        chk2("to_cause", tbus.fault_cause, 2'b11);
        chk1("to_req_valid", tbus.imem_req_valid, 1'b0);
      end
    end
    since++;

    bus.imem_req_ready = rdy;
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_err   = re;
    bus.imem_rsp_data  = rd;
    bus.inst_ready     = ir;
    bus.pc_next_valid  = pv;
    bus.pc_next        = pn;

    case (phase)
      P_REQ: begin
        n_stall = n_stall + 1;
        m_cnt++;
        if (m_cnt >= TO_MAIN) go_fault(2'b11);
        else if (rdy && !fresh) phase = P_WAIT;
      end
      P_WAIT: begin
        n_stall = n_stall + 1;
        m_cnt++;
        if (rv && re) go_fault(2'b01);
        else if (m_cnt >= TO_MAIN) go_fault(2'b11);
        else if (rv) begin
          m_inst = rd;
          phase  = P_HOLD;
          m_cnt  = 0;
        end
      end
      P_HOLD: if (ir) begin
        n_fire = n_fire + 1;
        if (pv) take_pc(pn);
        else phase = P_NEXT;
      end
      P_NEXT: if (pv) take_pc(pn);
      default: ;
    endcase
    fresh = 1'b0;
    @(negedge clk);
  endtask

  // Random handshakes; only pc_next values that will actually be sampled are kept aligned.
  task automatic rnd_cyc();
    logic [31:0] r, a, pn;
    bit rdy, rv, re, ir, pv;
    r   = $urandom();
    a   = $urandom() & 32'hFFFF_FFFC;
    rdy = ($urandom_range(0, 2) != 0);
    ir  = ($urandom_range(0, 1) == 1);
    pv  = ($urandom_range(0, 4) < 2);
    if (phase == P_WAIT) begin
      rv = ($urandom_range(0, 2) == 0);
      re = rv ? 1'b0 : ($urandom_range(0, 1) == 1);
    end else begin
      rv = ($urandom_range(0, 1) == 1);
      re = ($urandom_range(0, 1) == 1);
    end
    pn = (((phase == P_HOLD) && ir) || (phase == P_NEXT)) ? a : $urandom();
    cyc(rdy, rv, re, r, ir, pv, pn);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk1("rst_req_valid", bus.imem_req_valid, 1'b0);
    chk1("rst_inst_valid", bus.inst_valid, 1'b0);
    chk32("rst_inst", bus.inst, 32'd0);
    chk32("rst_inst_pc", bus.inst_pc, 32'd0);
    chk1("rst_fault", bus.fetch_fault, 1'b0);
    chk2("rst_cause", bus.fault_cause, 2'b00);
    chk1("rst_to_fault", tbus.fetch_fault, 1'b0);
`ifdef IFU_PERF_CNT_EN
    chk32("rst_perf_fetch", pf, 32'd0);
    chk32("rst_perf_stall", ps, 32'd0);
`endif
    phase   = P_REQ;
    fresh   = 1'b1;
    m_pc    = RST_PC;
    m_inst  = 32'd0;
    m_cnt   = 0;
    m_cause = 2'b00;
    n_fire  = 32'd0;
    n_stall = 32'd0;
    @(negedge clk);
    rst   = 1'b1;
    since = 0;
  endtask

  initial begin
    since = 100;
    bus.imem_req_ready  = 1'b0;
    bus.imem_rsp_valid  = 1'b0;
    bus.imem_rsp_err    = 1'b0;
    bus.imem_rsp_data   = 32'd0;
    bus.inst_ready      = 1'b0;
    bus.pc_next_valid   = 1'b0;
    bus.pc_next         = 32'd0;
    tbus.imem_req_ready = 1'b1;
    tbus.imem_rsp_valid = 1'b0;
    tbus.imem_rsp_err   = 1'b0;
    tbus.imem_rsp_data  = 32'd0;
    tbus.inst_ready     = 1'b0;
    tbus.pc_next_valid  = 1'b0;
    tbus.pc_next        = 32'd0;
    repeat (2) @(negedge clk);
    do_reset();

    // Request held 5 cycles against ready=0, fires on the 6th, response one cycle later.
    cyc(0, 0, 0, 32'd0, 0, 0, 32'd0);
    repeat (5) cyc(0, 0, 0, 32'd0, 0, 0, 32'd0);
    cyc(1, 0, 0, 32'd0, 0, 0, 32'd0);
    cyc(0, 1, 0, 32'h0010_0093, 0, 0, 32'd0);
    // Decode stalls 3 cycles (misaligned pc_next ignored while not firing), then accepts with next PC.
    repeat (3) cyc(0, 0, 0, 32'd0, 0, 1, 32'h8000_0006);
    cyc(0, 0, 0, 32'd0, 1, 1, 32'h8000_0004);
    cyc(1, 0, 0, 32'd0, 0, 0, 32'd0);

    repeat (400) rnd_cyc();

    // Misaligned next PC.
    do_reset();
    cyc(0, 0, 0, 32'd0, 0, 0, 32'd0);
    cyc(1, 0, 0, 32'd0, 0, 0, 32'd0);
    cyc(0, 1, 0, 32'h0000_0013, 0, 0, 32'd0);
    cyc(0, 0, 0, 32'd0, 1, 1, 32'h8000_0006);
    repeat (8) rnd_cyc();

    // Reset in WAIT, stale responses after release, then bus error.
    do_reset();
    cyc(0, 0, 0, 32'd0, 0, 0, 32'd0);
    cyc(1, 0, 0, 32'd0, 0, 0, 32'd0);
    cyc(0, 1, 0, 32'hDEAD_BEEF, 0, 0, 32'd0);
    do_reset();
    cyc(0, 1, 0, 32'hBAD0_0001, 0, 0, 32'd0);
    cyc(0, 1, 0, 32'hBAD0_0002, 0, 0, 32'd0);
    cyc(1, 1, 0, 32'hBAD0_0003, 0, 0, 32'd0);
    cyc(0, 1, 0, 32'h0000_0513, 0, 0, 32'd0);
    cyc(0, 0, 0, 32'd0, 1, 1, 32'h8000_0100);
    cyc(1, 0, 0, 32'd0, 0, 0, 32'd0);
    cyc(0, 1, 1, 32'hBAD0_0004, 0, 0, 32'd0);
    repeat (8) rnd_cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
